// File: rtl/mu_ddr_adapter_pkg.sv
// Shared types and default widths for the matrix-unit DDR AVMM adapter.
package mu_ddr_adapter_pkg;
    localparam int DDR_ADDR_W     = 33;
    localparam int DDR_DATA_W     = 8;
    localparam int STAT_W         = 16;
    localparam int TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDWAIT,
        RSP
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;
endpackage

// File: rtl/mu_sat_counter.sv
// Saturating event counter; one-cycle update latency, clear beats increment.
module mu_sat_counter #(
    parameter int width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [width-1:0] count_o
);
    logic [width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + width'(1);
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/mu_ddr_avmm_adapter.sv
// Single-outstanding request/response to AVMM host bridge with timeout and stats.
// Write rsp at T+2, read rsp at T+2+rdv latency; command held across waitrequest.
module mu_ddr_avmm_adapter
    import mu_ddr_adapter_pkg::*;
#(
    parameter int ddr_addr_w     = DDR_ADDR_W,
    parameter int ddr_data_w     = DDR_DATA_W,
    parameter int stat_w         = STAT_W,
    parameter int timeout_cycles = TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_read_i,
    input  logic                  req_write_i,
    input  logic [ddr_addr_w-1:0] req_addr_i,
    input  logic [ddr_data_w-1:0] req_wdata_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [ddr_data_w-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ddr_addr_w-1:0] avmm_address_o,
    output logic                  avmm_read_o,
    output logic                  avmm_write_o,
    output logic [ddr_data_w-1:0] avmm_writedata_o,
    input  logic                  avmm_waitreq_i,
    input  logic [ddr_data_w-1:0] avmm_readdata_i,
    input  logic                  avmm_readdatavalid_i,
    input  logic                  clr_stats_i,
    output logic [stat_w-1:0]     rd_count_o,
    output logic [stat_w-1:0]     wr_count_o,
    output logic                  timeout_o,
    output logic                  stray_rdv_o
);
    localparam int TW = $clog2(timeout_cycles + 1);

    state_e                state_q, state_d;
    op_e                   op_q;
    logic [ddr_addr_w-1:0] addr_q;
    logic [ddr_data_w-1:0] wdata_q, rdata_q;
    logic                  err_q, timeout_q, stray_q;
    logic [TW-1:0]         tmo_cnt_q;
    logic [stat_w-1:0]     rd_cnt, wr_cnt;

    logic req_any, req_both, accept, rd_done, wr_done, tmo_hit, tmo_abort, stray_rdv;

    assign req_any   = req_read_i | req_write_i;
    assign req_both  = req_read_i & req_write_i;
    assign accept    = (state_q == CMD) && !avmm_waitreq_i;
    assign rd_done   = (state_q == RDWAIT) && avmm_readdatavalid_i;
    assign wr_done   = accept && (op_q == OP_WRITE);
    assign tmo_hit   = (tmo_cnt_q == TW'(timeout_cycles - 1));
    // Completion on the final allowed cycle takes priority over the abort.
    assign tmo_abort = tmo_hit && (((state_q == CMD) && !accept) ||
                                   ((state_q == RDWAIT) && !avmm_readdatavalid_i));
    assign stray_rdv = avmm_readdatavalid_i && (state_q != RDWAIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = req_both ? RSP : CMD;
            CMD: begin
                if (accept)       state_d = (op_q == OP_WRITE) ? RSP : RDWAIT;
                else if (tmo_hit) state_d = RSP;
            end
            RDWAIT:  if (avmm_readdatavalid_i || tmo_hit) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        rsp_err_o        = 1'b0;
        rsp_rdata_o      = '0;
        avmm_address_o   = '0;
        avmm_writedata_o = '0;
        avmm_read_o      = 1'b0;
        avmm_write_o     = 1'b0;
        rd_count_o       = '0;
        wr_count_o       = '0;
        timeout_o        = 1'b0;
        stray_rdv_o      = 1'b0;
        if (!rst_i) begin
            req_ready_o      = (state_q == IDLE);
            rsp_valid_o      = (state_q == RSP);
            rsp_err_o        = (state_q == RSP) && err_q;
            rsp_rdata_o      = rdata_q;
            avmm_address_o   = addr_q;
            avmm_writedata_o = wdata_q;
            avmm_read_o      = (state_q == CMD) && (op_q == OP_READ);
            avmm_write_o     = (state_q == CMD) && (op_q == OP_WRITE);
            rd_count_o       = rd_cnt;
            wr_count_o       = wr_cnt;
            timeout_o        = timeout_q;
            stray_rdv_o      = stray_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req_any) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                op_q    <= req_write_i ? OP_WRITE : OP_READ;
                err_q   <= req_both;
            end else if (tmo_abort) begin
                err_q <= 1'b1;
            end
            if (state_q == IDLE) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == CMD) || (state_q == RDWAIT)) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
            if (rd_done) begin
                rdata_q <= avmm_readdata_i;
            end
            if (clr_stats_i)    timeout_q <= 1'b0;
            else if (tmo_abort) timeout_q <= 1'b1;
            if (clr_stats_i)    stray_q <= 1'b0;
            else if (stray_rdv) stray_q <= 1'b1;
        end
    end

    mu_sat_counter #(.width(stat_w)) u_rd_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (rd_done),
        .clr_i   (clr_stats_i),
        .count_o (rd_cnt)
    );

    mu_sat_counter #(.width(stat_w)) u_wr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (wr_done),
        .clr_i   (clr_stats_i),
        .count_o (wr_cnt)
    );
endmodule

// File: tb/tb_mu_ddr_avmm_adapter.sv
// Directed bench: stimulus queues expected responses, a negedge monitor checks them.
module tb_mu_ddr_avmm_adapter;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_read_i = 1'b0, req_write_i = 1'b0;
    logic [32:0] req_addr_i = '0;
    logic [7:0]  req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [7:0]  rsp_rdata_o;
    logic [32:0] avmm_address_o;
    logic        avmm_read_o, avmm_write_o;
    logic [7:0]  avmm_writedata_o;
    logic        avmm_waitreq_i = 1'b0;
    logic [7:0]  avmm_readdata_i = '0;
    logic        avmm_readdatavalid_i = 1'b0;
    logic        clr_stats_i = 1'b0;
    logic [1:0]  rd_count_o, wr_count_o;
    logic        timeout_o, stray_rdv_o;

    always #5 clk = ~clk;

    mu_ddr_avmm_adapter #(
        .ddr_addr_w(33), .ddr_data_w(8), .stat_w(2), .timeout_cycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .avmm_address_o(avmm_address_o), .avmm_read_o(avmm_read_o),
        .avmm_write_o(avmm_write_o), .avmm_writedata_o(avmm_writedata_o),
        .avmm_waitreq_i(avmm_waitreq_i), .avmm_readdata_i(avmm_readdata_i),
        .avmm_readdatavalid_i(avmm_readdatavalid_i), .clr_stats_i(clr_stats_i),
        .rd_count_o(rd_count_o), .wr_count_o(wr_count_o),
        .timeout_o(timeout_o), .stray_rdv_o(stray_rdv_o)
    );

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         cyc;
    } rsp_t;

    rsp_t       exp_q[$];
    int         cyc = 0;
    int         n_chk = 0, n_fail = 0;
    int         exp_rd = 0, exp_wr = 0;
    logic       exp_tmo = 1'b0, exp_stray = 1'b0;
    logic [7:0] last_rdata = '0;
    logic       prev_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", rsp_err_o, e.err);
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_cycle", cyc, e.cyc);
            end
            if (prev_vld) chk("rsp_pulse_width", 1, 0);
        end
        prev_vld = rsp_valid_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_rd_count"}, rd_count_o, exp_rd);
        chk({nm, "_wr_count"}, wr_count_o, exp_wr);
        chk({nm, "_timeout"}, timeout_o, exp_tmo);
        chk({nm, "_stray"}, stray_rdv_o, exp_stray);
    endtask

    task automatic do_write(input logic [32:0] a, input logic [7:0] d, input int nwait,
                            input logic clr);
        rsp_t e;
        chk("wr_ready", req_ready_o, 1);
        e.err = 1'b0; e.rdata = last_rdata; e.cyc = cyc + 2 + nwait;
        exp_q.push_back(e);
        req_write_i = 1'b1; req_addr_i = a; req_wdata_i = d;
        step();
        req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        for (int i = 0; i <= nwait; i++) begin
            avmm_waitreq_i = (i < nwait);
            if (i == nwait) clr_stats_i = clr;
            chk("wr_strobe", avmm_write_o, 1);
            chk("wr_no_read", avmm_read_o, 0);
            chk("wr_addr", avmm_address_o, a);
            chk("wr_data", avmm_writedata_o, d);
            step();
        end
        avmm_waitreq_i = 1'b0;
        clr_stats_i = 1'b0;
        if (clr) begin
            exp_wr = 0; exp_rd = 0; exp_tmo = 1'b0; exp_stray = 1'b0;
        end else begin
            exp_wr = (exp_wr == 3) ? 3 : exp_wr + 1;
        end
        chk("wr_strobe_drop", avmm_write_o, 0);
        chk_stats("wr");
        step();
    endtask

    task automatic do_read(input logic [32:0] a, input int lat, input logic [7:0] d);
        rsp_t e;
        chk("rd_ready", req_ready_o, 1);
        e.err = 1'b0; e.rdata = d; e.cyc = cyc + 2 + lat;
        exp_q.push_back(e);
        req_read_i = 1'b1; req_addr_i = a; avmm_waitreq_i = 1'b0;
        step();
        req_read_i = 1'b0; req_addr_i = '0;
        chk("rd_strobe", avmm_read_o, 1);
        chk("rd_addr", avmm_address_o, a);
        step();
        for (int j = 1; j <= lat; j++) begin
            chk("rdwait_no_strobe", avmm_read_o, 0);
            if (j == lat) begin
                avmm_readdatavalid_i = 1'b1; avmm_readdata_i = d;
            end
            step();
        end
        avmm_readdatavalid_i = 1'b0; avmm_readdata_i = '0;
        last_rdata = d;
        exp_rd = (exp_rd == 3) ? 3 : exp_rd + 1;
        chk_stats("rd");
        step();
    endtask

    initial begin
        rsp_t e;
        step();
        step();
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_strobes", {avmm_read_o, avmm_write_o}, 0);
        chk("rst_addr", avmm_address_o, 0);
        chk_stats("rst");
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", req_ready_o, 1);

        do_write(33'h1_0000_0010, 8'hA5, 3, 1'b0);
        do_read(33'h0_0000_0020, 4, 8'h3C);

        // Read that never returns data: abort 16 cycles after CMD entry.
        e.err = 1'b1; e.rdata = last_rdata; e.cyc = cyc + 17;
        exp_q.push_back(e);
        req_read_i = 1'b1; req_addr_i = 33'h0_0000_0040;
        step();
        req_read_i = 1'b0;
        chk("tmo_strobe", avmm_read_o, 1);
        repeat (16) step();
        exp_tmo = 1'b1;
        chk("tmo_strobe_drop", avmm_read_o, 0);
        chk_stats("tmo");
        step();
        avmm_readdatavalid_i = 1'b1; avmm_readdata_i = 8'h77;
        step();
        avmm_readdatavalid_i = 1'b0; avmm_readdata_i = '0;
        exp_stray = 1'b1;
        chk_stats("stray");
        chk("stray_rdata_kept", rsp_rdata_o, last_rdata);

        // Both request lines high: immediate error response, no AVMM access.
        e.err = 1'b1; e.rdata = last_rdata; e.cyc = cyc + 1;
        exp_q.push_back(e);
        req_read_i = 1'b1; req_write_i = 1'b1;
        step();
        req_read_i = 1'b0; req_write_i = 1'b0;
        chk("both_strobes", {avmm_read_o, avmm_write_o}, 0);
        chk_stats("both");
        step();

        // Reset while a read is stalled in CMD.
        req_read_i = 1'b1; req_addr_i = 33'h0_0000_0080; avmm_waitreq_i = 1'b1;
        step();
        req_read_i = 1'b0;
        chk("rst_mid_strobe", avmm_read_o, 1);
        rst_i = 1'b1;
        step();
        exp_rd = 0; exp_wr = 0; exp_tmo = 1'b0; exp_stray = 1'b0; last_rdata = '0;
        chk("rst_mid_strobe_drop", avmm_read_o, 0);
        chk("rst_mid_ready", req_ready_o, 0);
        chk_stats("rst_mid");
        rst_i = 1'b0; avmm_waitreq_i = 1'b0;
        #1;
        chk("rst_mid_ready_after", req_ready_o, 1);
        do_read(33'h1_2345_6789, 1, 8'h5A);

        // Saturation at 2 bits, then clear coinciding with a write completion.
        do_write(33'h0_0000_0100, 8'h01, 0, 1'b0);
        do_write(33'h0_0000_0101, 8'h02, 1, 1'b0);
        do_write(33'h0_0000_0102, 8'h03, 0, 1'b0);
        do_write(33'h0_0000_0103, 8'h04, 2, 1'b0);
        do_write(33'h0_0000_0104, 8'h05, 0, 1'b1);
        do_write(33'h0_0000_0105, 8'h06, 0, 1'b0);

        step();
        step();
        chk("rsp_missing", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
